// File: rtl/dma_cpl_router_if.sv
// Bundle of the ordering-record, completion and credit signals of dma_cpl_router.
// slave: the router's view. master: the environment driving records and XDMA done pulses.
interface dma_cpl_router_if #(
  parameter int unsigned N_REGIONS = 4,
  parameter int unsigned QDEPTH    = 16,
  parameter int unsigned LEN_BITS  = 28,
  parameter int unsigned PID_BITS  = 6,
  parameter int unsigned DEST_BITS = 4
);
  localparam int unsigned VF_BITS  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int unsigned CNT_BITS = $clog2(QDEPTH) + 1;

  logic                 s_ord_valid;
  logic                 s_ord_ready;
  logic [VF_BITS-1:0]   s_ord_vfid;
  logic [LEN_BITS-1:0]  s_ord_len;
  logic [PID_BITS-1:0]  s_ord_pid;
  logic [DEST_BITS-1:0] s_ord_dest;
  logic                 s_ord_last;
  logic                 dma_done;
  logic [N_REGIONS-1:0] m_done_valid;
  logic [N_REGIONS-1:0] m_done_ready;
  logic [PID_BITS-1:0]  m_done_pid;
  logic [DEST_BITS-1:0] m_done_dest;
  logic [LEN_BITS-1:0]  m_done_len;
  logic [N_REGIONS-1:0] xfer_out;
  logic [CNT_BITS-1:0]  outstanding;
  logic                 err_unexp;

  modport slave (
    input  s_ord_valid, s_ord_vfid, s_ord_len, s_ord_pid, s_ord_dest, s_ord_last,
    input  dma_done, m_done_ready,
    output s_ord_ready, m_done_valid, m_done_pid, m_done_dest, m_done_len,
    output xfer_out, outstanding, err_unexp
  );

  modport master (
    output s_ord_valid, s_ord_vfid, s_ord_len, s_ord_pid, s_ord_dest, s_ord_last,
    output dma_done, m_done_ready,
    input  s_ord_ready, m_done_valid, m_done_pid, m_done_dest, m_done_len,
    input  xfer_out, outstanding, err_unexp
  );
endinterface

// File: rtl/dma_cpl_router.sv
// Return-path completion router: matches in-order XDMA done pulses to queued ordering
// records, pulses a per-region credit on each match and, for records flagged last,
// presents a per-region completion with its payload until accepted.
module dma_cpl_router #(
  parameter int unsigned N_REGIONS = 4,
  parameter int unsigned QDEPTH    = 16,
  parameter int unsigned LEN_BITS  = 28,
  parameter int unsigned PID_BITS  = 6,
  parameter int unsigned DEST_BITS = 4
) (
  input logic              aclk,
  input logic              areset,
  dma_cpl_router_if.slave  bus
);
  localparam int unsigned VF_BITS  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int unsigned AW       = $clog2(QDEPTH);
  localparam int unsigned CNT_BITS = AW + 1;
  localparam logic [CNT_BITS-1:0]  CntOne = 1;
  localparam logic [N_REGIONS-1:0] RegOne = 1;

  typedef struct packed {
    logic [VF_BITS-1:0]   vfid;
    logic [LEN_BITS-1:0]  len;
    logic [PID_BITS-1:0]  pid;
    logic [DEST_BITS-1:0] dest;
    logic                 last;
  } entry_t;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  entry_t               mem_q [QDEPTH];
  entry_t               head, wr_entry;
  logic [CNT_BITS-1:0]  wr_ptr_q, rd_ptr_q, count;
  logic [CNT_BITS-1:0]  pend_q, pend_d;
  logic                 err_q, err_d;
  logic                 push, pop, full, empty, done_ok;
  state_e               state_q, state_d;
  logic [VF_BITS-1:0]   out_vfid_q, out_vfid_d;
  logic [PID_BITS-1:0]  out_pid_q, out_pid_d;
  logic [DEST_BITS-1:0] out_dest_q, out_dest_d;
  logic [LEN_BITS-1:0]  out_len_q, out_len_d;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = bus.s_ord_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_entry = '{vfid: bus.s_ord_vfid, len: bus.s_ord_len, pid: bus.s_ord_pid,
                      dest: bus.s_ord_dest, last: bus.s_ord_last};

  assign bus.s_ord_ready = !full;
  assign bus.outstanding = count;
  assign bus.err_unexp   = err_q;

  // Record storage; no reset needed since validity is tracked by the pointers.
  always_ff @(posedge aclk) begin
    if (!areset && push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  // Done accounting: a pulse with every queued entry already matched is dropped as an error.
  always_comb begin
    pend_d  = pend_q;
    err_d   = err_q;
    done_ok = bus.dma_done && (pend_q != count);
    if (bus.dma_done && !done_ok) begin
      err_d = 1'b1;
    end
    unique case ({done_ok, pop})
      2'b10:   pend_d = pend_q + CntOne;
      2'b01:   pend_d = pend_q - CntOne;
      default: pend_d = pend_q;
    endcase
  end

  // Pop/credit and completion FSM; pop is suppressed during reset so no credit leaks out.
  always_comb begin
    state_d          = state_q;
    pop              = 1'b0;
    out_vfid_d       = out_vfid_q;
    out_pid_d        = out_pid_q;
    out_dest_d       = out_dest_q;
    out_len_d        = out_len_q;
    bus.xfer_out     = '0;
    bus.m_done_valid = '0;
    bus.m_done_pid   = '0;
    bus.m_done_dest  = '0;
    bus.m_done_len   = '0;
    unique case (state_q)
      StIdle: begin
        if (!areset && (pend_q != '0) && !empty) begin
          pop          = 1'b1;
          bus.xfer_out = RegOne << head.vfid;
          if (head.last) begin
            state_d    = StSend;
            out_vfid_d = head.vfid;
            out_pid_d  = head.pid;
            out_dest_d = head.dest;
            out_len_d  = head.len;
          end
        end
      end
      StSend: begin
        bus.m_done_valid = RegOne << out_vfid_q;
        bus.m_done_pid   = out_pid_q;
        bus.m_done_dest  = out_dest_q;
        bus.m_done_len   = out_len_q;
        if (bus.m_done_ready[out_vfid_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointers, counters and the held completion payload.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      out_vfid_q <= '0;
      out_pid_q  <= '0;
      out_dest_q <= '0;
      out_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= push ? wr_ptr_q + CntOne : wr_ptr_q;
      rd_ptr_q   <= pop ? rd_ptr_q + CntOne : rd_ptr_q;
      pend_q     <= pend_d;
      err_q      <= err_d;
      out_vfid_q <= out_vfid_d;
      out_pid_q  <= out_pid_d;
      out_dest_q <= out_dest_d;
      out_len_q  <= out_len_d;
    end
  end
endmodule
